// File: rtl/ssd1306_spi_responder.sv
// Device-side model of the SSD1306 4-wire SPI port: oversamples the pins, deserialises bytes,
// decodes the command subset our driver issues and turns GDDRAM data into framebuffer writes.
module ssd1306_spi_responder #(
    parameter int COLS        = 128,
    parameter int PAGES       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CW = $clog2(COLS),
    localparam int PW = $clog2(PAGES),
    localparam int AW = $clog2(COLS * PAGES)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_SPI_Clk,
    input  logic          i_SPI_MOSI,
    input  logic          i_SPI_CS_n,
    input  logic          i_DC,
    input  logic          i_RES_n,
    output logic [7:0]    o_Byte,
    output logic          o_Byte_DV,
    output logic          o_Byte_Is_Data,
    output logic          o_Fb_We,
    output logic [AW-1:0] o_Fb_Addr,
    output logic [7:0]    o_Fb_Data,
    output logic          o_Display_On,
    output logic [7:0]    o_Contrast
);

    // state    | meaning
    // IDLE     | waiting for a command opcode
    // COL_S    | next command byte is column start
    // COL_E    | next command byte is column end
    // PAGE_S   | next command byte is page start
    // PAGE_E   | next command byte is page end
    // CONTRAST | next command byte is contrast value
    // SKIP1    | swallow one argument byte
    // SKIP2    | swallow two argument bytes
    typedef enum logic [2:0] {
        IDLE, COL_S, COL_E, PAGE_S, PAGE_E, CONTRAST, SKIP1, SKIP2
    } parse_state_t;

    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);
    localparam logic [AW-1:0] COLS_W   = AW'(COLS);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, dc_sync, res_sync;
    logic sclk_s, mosi_s, cs_s, dc_s, res_s;
    logic sclk_prev;
    logic sclk_rise;

    parse_state_t state;
    logic [2:0]    bit_cnt;
    logic [6:0]    shift;
    logic [7:0]    rx_byte;
    logic          rx_dc;
    logic          rx_valid;
    logic [CW-1:0] col_start, col_end, col_ptr;
    logic [PW-1:0] page_start, page_end, page_ptr;
    logic [AW-1:0] wr_addr;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign res_s     = res_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign wr_addr   = AW'(page_ptr) * COLS_W + AW'(col_ptr);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            dc_sync   <= '0;
            res_sync  <= '1;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], i_DC};
            res_sync  <= {res_sync[SYNC_STAGES-2:0], i_RES_n};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift          <= '0;
            rx_byte        <= '0;
            rx_dc          <= 1'b0;
            rx_valid       <= 1'b0;
            o_Byte         <= '0;
            o_Byte_DV      <= 1'b0;
            o_Byte_Is_Data <= 1'b0;
            o_Fb_We        <= 1'b0;
            o_Fb_Addr      <= '0;
            o_Fb_Data      <= '0;
            o_Display_On   <= 1'b0;
            o_Contrast     <= 8'h7F;
            col_start      <= '0;
            col_end        <= COL_MAX;
            col_ptr        <= '0;
            page_start     <= '0;
            page_end       <= PAGE_MAX;
            page_ptr       <= '0;
        end else if (!res_s) begin
            // RES pin: same state as power-on reset, applied synchronously
            state          <= IDLE;
            bit_cnt        <= '0;
            shift          <= '0;
            rx_byte        <= '0;
            rx_dc          <= 1'b0;
            rx_valid       <= 1'b0;
            o_Byte         <= '0;
            o_Byte_DV      <= 1'b0;
            o_Byte_Is_Data <= 1'b0;
            o_Fb_We        <= 1'b0;
            o_Fb_Addr      <= '0;
            o_Fb_Data      <= '0;
            o_Display_On   <= 1'b0;
            o_Contrast     <= 8'h7F;
            col_start      <= '0;
            col_end        <= COL_MAX;
            col_ptr        <= '0;
            page_start     <= '0;
            page_end       <= PAGE_MAX;
            page_ptr       <= '0;
        end else begin
            o_Byte_DV <= 1'b0;
            o_Fb_We   <= 1'b0;
            rx_valid  <= 1'b0;

            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift   <= {shift[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte  <= {shift, mosi_s};
                    rx_dc    <= dc_s;
                    rx_valid <= 1'b1;
                end
            end

            if (rx_valid) begin
                o_Byte         <= rx_byte;
                o_Byte_Is_Data <= rx_dc;
                o_Byte_DV      <= 1'b1;
                if (rx_dc) begin
                    // Data always lands in the framebuffer, even if a command was mid-argument
                    state     <= IDLE;
                    o_Fb_We   <= 1'b1;
                    o_Fb_Addr <= wr_addr;
                    o_Fb_Data <= rx_byte;
                    if (col_ptr == col_end || col_ptr == COL_MAX) begin
                        col_ptr <= col_start;
                        if (page_ptr == page_end || page_ptr == PAGE_MAX)
                            page_ptr <= page_start;
                        else
                            page_ptr <= page_ptr + 1'b1;
                    end else begin
                        col_ptr <= col_ptr + 1'b1;
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            case (rx_byte)
                                8'h21: state <= COL_S;
                                8'h22: state <= PAGE_S;
                                8'h81: state <= CONTRAST;
                                8'h20, 8'hA8, 8'hD3, 8'hD5,
                                8'hD9, 8'hDA, 8'hDB, 8'h8D: state <= SKIP1;
                                8'hAE: o_Display_On <= 1'b0;
                                8'hAF: o_Display_On <= 1'b1;
                                default: state <= IDLE;
                            endcase
                        end
                        COL_S: begin
                            col_start <= rx_byte[CW-1:0];
                            state     <= COL_E;
                        end
                        COL_E: begin
                            col_end <= rx_byte[CW-1:0];
                            col_ptr <= col_start;
                            state   <= IDLE;
                        end
                        PAGE_S: begin
                            page_start <= rx_byte[PW-1:0];
                            state      <= PAGE_E;
                        end
                        PAGE_E: begin
                            page_end <= rx_byte[PW-1:0];
                            page_ptr <= page_start;
                            state    <= IDLE;
                        end
                        CONTRAST: begin
                            o_Contrast <= rx_byte;
                            state      <= IDLE;
                        end
                        SKIP1:   state <= IDLE;
                        SKIP2:   state <= SKIP1;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
